// File: rtl/uart_rx_cmd_ctrl.sv
// Command-frame controller behind the UART receiver: parses write/read frames,
// drives the register-file port, returns read data to the transmitter and counts frame errors.
module uart_rx_cmd_ctrl #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      ADDR_WIDTH    = 4,
    parameter int unsigned      TIMEOUT_WIDTH = 16,
    parameter logic [WIDTH-1:0] WR_CMD        = 8'hAA,
    parameter logic [WIDTH-1:0] RD_CMD        = 8'hBB
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic                     RX_PAR_ERR,
    input  logic                     RX_STP_ERR,
    input  logic [TIMEOUT_WIDTH-1:0] Timeout,
    output logic [ADDR_WIDTH-1:0]    RF_Addr,
    output logic [WIDTH-1:0]         RF_WrData,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    input  logic [WIDTH-1:0]         RF_RdData,
    input  logic                     RF_RdData_Valid,
    output logic [WIDTH-1:0]         TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_Busy,
    output logic                     Frame_Err,
    output logic [7:0]               Err_Cnt,
    output logic                     Busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t                   state, state_nxt;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     rx_byte, rx_err, tmo_hit;
    logic                     fe_nxt, wr_stb, rd_stb, tx_stb;
    logic                     addr_ld, wdata_ld, tx_ld, cnt_clr, cnt_inc;

    assign rx_byte = RX_D_VLD;
    assign rx_err  = RX_PAR_ERR | RX_STP_ERR;
    assign tmo_hit = (Timeout != '0) && (tmo_cnt == Timeout);

    always_comb begin
        state_nxt = state;
        fe_nxt    = 1'b0;
        wr_stb    = 1'b0;
        rd_stb    = 1'b0;
        tx_stb    = 1'b0;
        addr_ld   = 1'b0;
        wdata_ld  = 1'b0;
        tx_ld     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_err) begin
                    fe_nxt = 1'b1;
                end else if (rx_byte) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_nxt = WR_ADDR;
                        cnt_clr   = 1'b1;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_nxt = RD_ADDR;
                        cnt_clr   = 1'b1;
                    end else begin
                        fe_nxt = 1'b1;
                    end
                end
            end
            WR_ADDR, WR_DATA, RD_ADDR: begin
                // err beats a simultaneous byte; an accepted byte beats the timeout
                if (rx_err) begin
                    fe_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else if (rx_byte) begin
                    if (state == WR_ADDR) begin
                        addr_ld   = 1'b1;
                        state_nxt = WR_DATA;
                        cnt_clr   = 1'b1;
                    end else if (state == WR_DATA) begin
                        wdata_ld  = 1'b1;
                        wr_stb    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        addr_ld   = 1'b1;
                        rd_stb    = 1'b1;
                        state_nxt = RD_WAIT;
                        cnt_clr   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    fe_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RD_WAIT: begin
                // errors and overruns here are counted but never abort the read
                if (rx_err || rx_byte) fe_nxt = 1'b1;
                if (RF_RdData_Valid) begin
                    tx_ld     = 1'b1;
                    state_nxt = TX_SEND;
                end else if (tmo_hit) begin
                    fe_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            TX_SEND: begin
                if (rx_err || rx_byte) fe_nxt = 1'b1;
                if (!TX_Busy) begin
                    tx_stb    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            RF_Addr   <= '0;
            RF_WrData <= '0;
            RF_WrEn   <= 1'b0;
            RF_RdEn   <= 1'b0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            Frame_Err <= 1'b0;
            Err_Cnt   <= '0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            RF_WrEn   <= wr_stb;
            RF_RdEn   <= rd_stb;
            TX_D_VLD  <= tx_stb;
            Frame_Err <= fe_nxt;
            // Busy stays up through the final strobe cycle and drops right after it
            Busy      <= (state_nxt != IDLE) | wr_stb | tx_stb;
            if (cnt_clr) begin
                tmo_cnt <= '0;
            end else if (cnt_inc) begin
                tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
            end
            if (addr_ld)  RF_Addr   <= RX_P_DATA[ADDR_WIDTH-1:0];
            if (wdata_ld) RF_WrData <= RX_P_DATA;
            if (tx_ld)    TX_P_DATA <= RF_RdData;
            if (fe_nxt && (Err_Cnt != 8'hFF)) Err_Cnt <= Err_Cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl: write/read frames, errors, overrun, timeout,
// error-count saturation and asynchronous reset mid-frame.
module tb_uart_rx_cmd_ctrl;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic        RX_PAR_ERR;
    logic        RX_STP_ERR;
    logic [15:0] Timeout;
    logic [3:0]  RF_Addr;
    logic [7:0]  RF_WrData;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_Valid;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_Busy;
    logic        Frame_Err;
    logic [7:0]  Err_Cnt;
    logic        Busy;

    int n_checks = 0;
    int n_errors = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int tx_pulses = 0;
    int fe_pulses = 0;

    uart_rx_cmd_ctrl #(
        .WIDTH(8),
        .ADDR_WIDTH(4),
        .TIMEOUT_WIDTH(16),
        .WR_CMD(8'hAA),
        .RD_CMD(8'hBB)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_P_DATA(RX_P_DATA),
        .RX_D_VLD(RX_D_VLD),
        .RX_PAR_ERR(RX_PAR_ERR),
        .RX_STP_ERR(RX_STP_ERR),
        .Timeout(Timeout),
        .RF_Addr(RF_Addr),
        .RF_WrData(RF_WrData),
        .RF_WrEn(RF_WrEn),
        .RF_RdEn(RF_RdEn),
        .RF_RdData(RF_RdData),
        .RF_RdData_Valid(RF_RdData_Valid),
        .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD),
        .TX_Busy(TX_Busy),
        .Frame_Err(Frame_Err),
        .Err_Cnt(Err_Cnt),
        .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RF_WrEn)   wr_pulses++;
        if (RF_RdEn)   rd_pulses++;
        if (TX_D_VLD)  tx_pulses++;
        if (Frame_Err) fe_pulses++;
    end

    // After tick() the outputs reflect the edge just taken; inputs set now hit the next edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({RF_Addr, RF_WrData, RF_WrEn, RF_RdEn, TX_P_DATA, TX_D_VLD, Frame_Err, Err_Cnt, Busy} !== 35'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got addr=%h wd=%h we=%b re=%b tx=%h tv=%b fe=%b ec=%0d busy=%b want all 0",
                     RF_Addr, RF_WrData, RF_WrEn, RF_RdEn, TX_P_DATA, TX_D_VLD, Frame_Err, Err_Cnt, Busy);
        end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_pulses;
        send_byte(8'hAA);
        n_checks++;
        if (Busy !== 1'b1) begin n_errors++; $display("FAIL wr_busy_rise: got %b want 1", Busy); end
        send_byte(8'h05);
        send_byte(8'h3C);
        n_checks++;
        if ({RF_WrEn, RF_Addr, RF_WrData, Busy} !== {1'b1, 4'h5, 8'h3C, 1'b1}) begin
            n_errors++;
            $display("FAIL wr_strobe: got we=%b addr=%h data=%h busy=%b want we=1 addr=5 data=3c busy=1",
                     RF_WrEn, RF_Addr, RF_WrData, Busy);
        end
        tick();
        n_checks++;
        if ({RF_WrEn, Busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL wr_after: got we=%b busy=%b want 0 0", RF_WrEn, Busy);
        end
        n_checks++;
        if ((wr_pulses - w0) !== 1 || Err_Cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL wr_count: got pulses=%0d errcnt=%0d want 1 0", wr_pulses - w0, Err_Cnt);
        end
        // spaced bytes, address taken from low bits only
        send_byte(8'hAA);
        repeat (3) tick();
        send_byte(8'h1A);
        repeat (5) tick();
        send_byte(8'h55);
        n_checks++;
        if ({RF_WrEn, RF_Addr, RF_WrData} !== {1'b1, 4'hA, 8'h55}) begin
            n_errors++;
            $display("FAIL wr_spaced: got we=%b addr=%h data=%h want 1 a 55", RF_WrEn, RF_Addr, RF_WrData);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        send_byte(8'hAA);
        send_byte(8'h06);
        send_byte(8'h77);
        n_checks++;
        if ({RF_WrEn, RF_Addr, RF_WrData} !== {1'b1, 4'h6, 8'h77}) begin
            n_errors++;
            $display("FAIL b2b_first: got we=%b addr=%h data=%h want 1 6 77", RF_WrEn, RF_Addr, RF_WrData);
        end
        tick();
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h99);
        n_checks++;
        if ({RF_WrEn, RF_Addr, RF_WrData, Err_Cnt} !== {1'b1, 4'h2, 8'h99, 8'd0}) begin
            n_errors++;
            $display("FAIL b2b_second: got we=%b addr=%h data=%h ec=%0d want 1 2 99 0",
                     RF_WrEn, RF_Addr, RF_WrData, Err_Cnt);
        end
        tick();
    endtask

    task automatic test_read();
        int r0, t0, early;
        r0 = rd_pulses;
        t0 = tx_pulses;
        early = 0;
        TX_Busy = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h07);
        n_checks++;
        if ({RF_RdEn, RF_Addr} !== {1'b1, 4'h7}) begin
            n_errors++;
            $display("FAIL rd_strobe: got re=%b addr=%h want 1 7", RF_RdEn, RF_Addr);
        end
        tick();
        tick();
        RF_RdData       = 8'h9E;
        RF_RdData_Valid = 1'b1;
        tick();
        RF_RdData_Valid = 1'b0;
        RF_RdData       = 8'h00;
        n_checks++;
        if ({TX_P_DATA, Busy} !== {8'h9E, 1'b1}) begin
            n_errors++;
            $display("FAIL rd_capture: got tx=%h busy=%b want 9e 1", TX_P_DATA, Busy);
        end
        repeat (6) begin
            tick();
            if (TX_D_VLD) early++;
        end
        TX_Busy = 1'b0;
        tick();
        n_checks++;
        if ({early[7:0], TX_D_VLD, TX_P_DATA} !== {8'd0, 1'b1, 8'h9E}) begin
            n_errors++;
            $display("FAIL rd_tx: got early=%0d tv=%b tx=%h want 0 1 9e", early, TX_D_VLD, TX_P_DATA);
        end
        tick();
        n_checks++;
        if ((rd_pulses - r0) !== 1 || (tx_pulses - t0) !== 1 || Busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_counts: got rd=%0d tx=%0d busy=%b want 1 1 0", rd_pulses - r0, tx_pulses - t0, Busy);
        end
    endtask

    task automatic test_bad_cmd();
        send_byte(8'h12);
        n_checks++;
        if ({Frame_Err, Err_Cnt, Busy} !== {1'b1, 8'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL bad_cmd: got fe=%b ec=%0d busy=%b want 1 1 0", Frame_Err, Err_Cnt, Busy);
        end
        tick();
        n_checks++;
        if ({Frame_Err, Busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL bad_cmd_after: got fe=%b busy=%b want 0 0", Frame_Err, Busy);
        end
    endtask

    task automatic test_err_mid_frame();
        int w0, r0;
        w0 = wr_pulses;
        r0 = rd_pulses;
        send_byte(8'hAA);
        send_byte(8'h05);
        RX_PAR_ERR = 1'b1;
        send_byte(8'h3C);
        RX_PAR_ERR = 1'b0;
        n_checks++;
        if ({Frame_Err, RF_WrEn, Busy, Err_Cnt} !== {1'b1, 1'b0, 1'b0, 8'd2}) begin
            n_errors++;
            $display("FAIL par_abort: got fe=%b we=%b busy=%b ec=%0d want 1 0 0 2", Frame_Err, RF_WrEn, Busy, Err_Cnt);
        end
        tick();
        send_byte(8'hBB);
        RX_STP_ERR = 1'b1;
        send_byte(8'h07);
        RX_STP_ERR = 1'b0;
        tick();
        n_checks++;
        if ((wr_pulses - w0) !== 0 || (rd_pulses - r0) !== 0 || Err_Cnt !== 8'd3 || Busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stp_abort: got wr=%0d rd=%0d ec=%0d busy=%b want 0 0 3 0",
                     wr_pulses - w0, rd_pulses - r0, Err_Cnt, Busy);
        end
        RX_PAR_ERR = 1'b1;
        tick();
        RX_PAR_ERR = 1'b0;
        n_checks++;
        if ({Frame_Err, Err_Cnt, Busy} !== {1'b1, 8'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL idle_err: got fe=%b ec=%0d busy=%b want 1 4 0", Frame_Err, Err_Cnt, Busy);
        end
    endtask

    task automatic test_overrun();
        TX_Busy = 1'b0;
        send_byte(8'hBB);
        send_byte(8'h03);
        tick();
        send_byte(8'h55);
        n_checks++;
        if ({Frame_Err, Busy, Err_Cnt} !== {1'b1, 1'b1, 8'd5}) begin
            n_errors++;
            $display("FAIL overrun: got fe=%b busy=%b ec=%0d want 1 1 5", Frame_Err, Busy, Err_Cnt);
        end
        RF_RdData       = 8'hC3;
        RF_RdData_Valid = 1'b1;
        tick();
        RF_RdData_Valid = 1'b0;
        tick();
        n_checks++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'hC3}) begin
            n_errors++;
            $display("FAIL overrun_tx: got tv=%b tx=%h want 1 c3", TX_D_VLD, TX_P_DATA);
        end
        tick();
    endtask

    task automatic test_timeout();
        int k, f0;
        Timeout = 16'd100;
        send_byte(8'hAA);
        k = 0;
        while (k < 200) begin
            tick();
            k++;
            if (Frame_Err) break;
        end
        n_checks++;
        if (k !== 101 || Busy !== 1'b0 || Err_Cnt !== 8'd6) begin
            n_errors++;
            $display("FAIL timeout_100: got edges=%0d busy=%b ec=%0d want 101 0 6", k, Busy, Err_Cnt);
        end
        tick();
        // a byte on the very cycle the count reaches Timeout is still accepted
        send_byte(8'hAA);
        repeat (100) tick();
        send_byte(8'h05);
        n_checks++;
        if ({Frame_Err, Busy} !== 2'b01) begin
            n_errors++;
            $display("FAIL timeout_edge: got fe=%b busy=%b want 0 1", Frame_Err, Busy);
        end
        send_byte(8'h3C);
        n_checks++;
        if ({RF_WrEn, RF_Addr, Err_Cnt} !== {1'b1, 4'h5, 8'd6}) begin
            n_errors++;
            $display("FAIL timeout_edge_wr: got we=%b addr=%h ec=%0d want 1 5 6", RF_WrEn, RF_Addr, Err_Cnt);
        end
        tick();
        Timeout = 16'd0;
        f0 = fe_pulses;
        send_byte(8'hAA);
        repeat (10000) tick();
        n_checks++;
        if ((fe_pulses - f0) !== 0 || Busy !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_off: got fe=%0d busy=%b want 0 1", fe_pulses - f0, Busy);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        n_checks++;
        if ({RF_WrEn, RF_Addr, RF_WrData} !== {1'b1, 4'h1, 8'h02}) begin
            n_errors++;
            $display("FAIL timeout_off_wr: got we=%b addr=%h data=%h want 1 1 02", RF_WrEn, RF_Addr, RF_WrData);
        end
        tick();
    endtask

    task automatic test_saturation_reset();
        int w0, f0;
        for (int i = 0; i < 300; i++) send_byte(8'h00);
        tick();
        n_checks++;
        if (Err_Cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL saturate: got %0d want 255", Err_Cnt);
        end
        send_byte(8'hAA);
        send_byte(8'h05);
        RST = 1'b0;
        #1;
        n_checks++;
        if ({RF_Addr, RF_WrData, RF_WrEn, RF_RdEn, TX_P_DATA, TX_D_VLD, Frame_Err, Err_Cnt, Busy} !== 35'd0) begin
            n_errors++;
            $display("FAIL async_reset: got addr=%h wd=%h tx=%h ec=%0d busy=%b want all 0",
                     RF_Addr, RF_WrData, TX_P_DATA, Err_Cnt, Busy);
        end
        #2;
        RST = 1'b1;
        w0 = wr_pulses;
        f0 = fe_pulses;
        repeat (20) tick();
        n_checks++;
        if ((wr_pulses - w0) !== 0 || (fe_pulses - f0) !== 0 || Busy !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset: got wr=%0d fe=%0d busy=%b want 0 0 0", wr_pulses - w0, fe_pulses - f0, Busy);
        end
        send_byte(8'h3C);
        n_checks++;
        if ({RF_WrEn, Frame_Err, Err_Cnt} !== {1'b0, 1'b1, 8'd1}) begin
            n_errors++;
            $display("FAIL dropped_frame: got we=%b fe=%b ec=%0d want 0 1 1", RF_WrEn, Frame_Err, Err_Cnt);
        end
    endtask

    initial begin
        RST             = 1'b0;
        RX_P_DATA       = 8'h00;
        RX_D_VLD        = 1'b0;
        RX_PAR_ERR      = 1'b0;
        RX_STP_ERR      = 1'b0;
        Timeout         = 16'd0;
        RF_RdData       = 8'h00;
        RF_RdData_Valid = 1'b0;
        TX_Busy         = 1'b0;
        test_reset();
        test_write();
        test_back_to_back();
        test_read();
        test_bad_cmd();
        test_err_mid_frame();
        test_overrun();
        test_timeout();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
